pe_row_db: RTL and testbench

- Parametrised weight-stationary systolic PE row; the successor to the fixed 32-bit row.
- One activation stream enters on the left, is registered per PE, and passes right.
- Each PE holds double-buffered weights: a shadow buffer (loaded from above, forwarded below) and an active buffer (used for MAC).
- A drain-then-swap FSM with a valid/ready handshake replaces active weights safely while data is in flight. Rows are stacked vertically to form the array.

---
 rtl/pe_row_db_pkg.sv | 32 +++
 rtl/pe_row_db_cell.sv | 81 ++++++++
 rtl/pe_row_db.sv | 97 +++++++++
 tb/tb_pe_row_db.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_row_db_pkg.sv
// Shared definitions for the double-buffered PE row: swap FSM states,
// default widths and the saturation helper used when PE_ROW_SAT_EN is defined.
package pe_pkg;

  localparam int unsigned DEF_NUM_PE = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ACC_W  = 32;

  // Widest accumulator the saturation helper can handle
  localparam int unsigned SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } row_state_e;

  // Clamp a (w+1)-bit signed sum held in a wide container to the w-bit signed range
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W:0] x,
    input int unsigned               w
  );
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (x > hi)      return hi[SAT_MAX_W-1:0];
    else if (x < lo) return lo[SAT_MAX_W-1:0];
    else             return x[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pe_row_db_cell.sv
// One weight-stationary PE: activation stage, shadow/active weight buffers and MAC.
// Optional feature macro: PE_ROW_SAT_EN (saturating accumulate instead of wrap).
module pe_cell_db
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              w_en_i,
  input  logic              swap_i,
  input  logic              opsel_i,
  input  logic [DATA_W-1:0] act_i,
  input  logic              act_valid_i,
  input  logic [DATA_W-1:0] w_above_i,
  input  logic [ACC_W-1:0]  sum_i,
  output logic [DATA_W-1:0] act_o,
  output logic              act_valid_o,
  output logic [DATA_W-1:0] shadow_o,
  output logic [ACC_W-1:0]  sum_o,
  output logic              valid_o
);

  logic signed [DATA_W-1:0]   a_q;
  logic                       v_q;
  logic        [DATA_W-1:0]   shadow_q;
  logic signed [DATA_W-1:0]   active_q;
  logic        [ACC_W-1:0]    sum_q;
  logic        [ACC_W-1:0]    sum_d;
  logic                       valid_q;
  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    addend;

`ifdef PE_ROW_SAT_EN
  logic signed [ACC_W:0]       wide;
  logic signed [SAT_MAX_W:0]   wide_x;
  logic signed [SAT_MAX_W-1:0] sat_res;
`endif

  always_comb begin
    prod   = a_q * active_q;
    addend = opsel_i ? '0 : sum_i;
`ifdef PE_ROW_SAT_EN
    // One extra bit holds the true sum so overflow is visible before clamping
    wide    = (ACC_W+1)'(signed'(addend)) + (ACC_W+1)'(prod);
    wide_x  = (SAT_MAX_W+1)'(wide);
    sat_res = saturate(wide_x, ACC_W);
    sum_d   = sat_res[ACC_W-1:0];
`else
    sum_d   = addend + ACC_W'(prod);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      v_q      <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
    end else if (en_i) begin
      a_q     <= act_i;
      v_q     <= act_valid_i;
      sum_q   <= sum_d;
      valid_q <= v_q;
      if (w_en_i) shadow_q <= w_above_i;
      // Non-blocking read of shadow_q keeps the pre-write value on a same-cycle W_EN
      if (swap_i) active_q <= shadow_q;
    end
  end

  assign act_o       = a_q;
  assign act_valid_o = v_q;
  assign shadow_o    = shadow_q;
  assign sum_o       = sum_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/pe_row_db.sv
// Weight-stationary systolic PE row with double-buffered weights and a
// drain-then-swap controller. Optional feature macro: PE_ROW_SAT_EN.
module pe_row_db
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE = DEF_NUM_PE,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     EN,
  input  logic                     W_EN,
  input  logic                     W_SWAP,
  input  logic                     OPSEL,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [DATA_W-1:0]        act_in,
  output logic [DATA_W-1:0]        act_out,
  output logic                     act_out_valid,
  input  logic [NUM_PE*DATA_W-1:0] in_weight_above,
  output logic [NUM_PE*DATA_W-1:0] out_weight_below,
  input  logic [NUM_PE*ACC_W-1:0]  in_sum,
  output logic [NUM_PE*ACC_W-1:0]  out_sum,
  output logic [NUM_PE-1:0]        out_valid,
  output logic                     swap_done
);

  row_state_e        state_q;
  logic              swap_done_q;
  logic              swap_fire;
  logic              accept;
  logic [DATA_W-1:0] a_vec [NUM_PE];
  logic [NUM_PE-1:0] v_vec;

  assign act_ready = EN && (state_q == RUN);
  assign accept    = act_valid && act_ready;
  assign swap_fire = EN && (state_q == SWAP);

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    logic [DATA_W-1:0] act_src;
    logic              vld_src;
    if (i == 0) begin : g_head
      assign act_src = act_in;
      assign vld_src = accept;
    end else begin : g_tail
      assign act_src = a_vec[i-1];
      assign vld_src = v_vec[i-1];
    end

    pe_cell_db #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_cell (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .en_i        (EN),
      .w_en_i      (W_EN),
      .swap_i      (swap_fire),
      .opsel_i     (OPSEL),
      .act_i       (act_src),
      .act_valid_i (vld_src),
      .w_above_i   (in_weight_above[i*DATA_W +: DATA_W]),
      .sum_i       (in_sum[i*ACC_W +: ACC_W]),
      .act_o       (a_vec[i]),
      .act_valid_o (v_vec[i]),
      .shadow_o    (out_weight_below[i*DATA_W +: DATA_W]),
      .sum_o       (out_sum[i*ACC_W +: ACC_W]),
      .valid_o     (out_valid[i])
    );
  end

  assign act_out       = a_vec[NUM_PE-1];
  assign act_out_valid = v_vec[NUM_PE-1];

  // Swap controller: stop intake, wait for the activation pipe to empty, then swap
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      swap_done_q <= 1'b0;
    end else if (EN) begin
      swap_done_q <= 1'b0;
      unique case (state_q)
        RUN:   if (W_SWAP) state_q <= DRAIN;
        DRAIN: if (v_vec == '0) state_q <= SWAP;
        SWAP: begin
          state_q     <= RUN;
          swap_done_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign swap_done = swap_done_q;

endmodule

// File: tb/tb_pe_row_db.sv
// Directed self-checking bench for pe_row_db (4x8-bit/32-bit row plus a 2x8-bit/16-bit row
// for accumulator overflow; build with PE_ROW_SAT_EN to expect saturation).
module tb_pe_row_db;

  logic         clk;
  logic         rst, en, w_en, w_swap, opsel, act_valid;
  logic         act_ready, act_out_valid, swap_done;
  logic [7:0]   act_in, act_out;
  logic [31:0]  win, wbelow;
  logic [127:0] sum_in, out_sum;
  logic [3:0]   out_valid;

  logic         s_w_en, s_w_swap, s_act_valid, s_act_ready, s_act_out_valid, s_swap_done;
  logic [7:0]   s_act_in, s_act_out;
  logic [15:0]  s_win, s_wbelow;
  logic [31:0]  s_sum, s_out_sum;
  logic [1:0]   s_out_valid;

  int total = 0;
  int bad   = 0;

`ifdef PE_ROW_SAT_EN
  localparam logic [15:0] POS_OVF_EXP = 16'h7FFF;
  localparam logic [15:0] NEG_OVF_EXP = 16'h8000;
`else
  localparam logic [15:0] POS_OVF_EXP = 16'h8000;
  localparam logic [15:0] NEG_OVF_EXP = 16'h7FFF;
`endif

  pe_row_db #(.NUM_PE(4), .DATA_W(8), .ACC_W(32)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .W_EN(w_en), .W_SWAP(w_swap), .OPSEL(opsel),
    .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in), .act_out(act_out),
    .act_out_valid(act_out_valid), .in_weight_above(win), .out_weight_below(wbelow),
    .in_sum(sum_in), .out_sum(out_sum), .out_valid(out_valid), .swap_done(swap_done)
  );

  pe_row_db #(.NUM_PE(2), .DATA_W(8), .ACC_W(16)) dut16 (
    .CLK(clk), .RESET(rst), .EN(en), .W_EN(s_w_en), .W_SWAP(s_w_swap), .OPSEL(opsel),
    .act_valid(s_act_valid), .act_ready(s_act_ready), .act_in(s_act_in), .act_out(s_act_out),
    .act_out_valid(s_act_out_valid), .in_weight_above(s_win), .out_weight_below(s_wbelow),
    .in_sum(s_sum), .out_sum(s_out_sum), .out_valid(s_out_valid), .swap_done(s_swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] osum(input int i);
    return out_sum[i*32 +: 32];
  endfunction

  task automatic flush();
    act_valid = 1'b0;
    act_in    = '0;
    repeat (6) tick();
  endtask

  task automatic load_weights(input logic [31:0] w);
    logic got;
    win  = w;
    w_en = 1'b1;
    tick();
    w_en   = 1'b0;
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (swap_done) got = 1'b1;
    end
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL load_swap_done got=%b exp=1 (timeout)", got); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (out_sum !== '0) begin bad++; $display("FAIL rst_out_sum got=%h exp=0", out_sum); end
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL rst_swap_done got=%b exp=0", swap_done); end
    total++; if (wbelow !== 32'h0) begin bad++; $display("FAIL rst_wbelow got=%h exp=0", wbelow); end
    total++; if (act_out_valid !== 1'b0) begin bad++; $display("FAIL rst_act_out_valid got=%b exp=0", act_out_valid); end
    total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL rst_act_ready got=%b exp=1", act_ready); end
    total++; if (s_out_sum !== 32'h0) begin bad++; $display("FAIL rst_s_out_sum got=%h exp=0", s_out_sum); end
  endtask

  task automatic test_mac(input logic op, input logic [31:0] base);
    logic [3:0]  ev;
    logic [31:0] es;
    load_weights({8'd4, 8'd3, 8'd2, 8'd1});
    total++; if (wbelow !== 32'h04030201) begin bad++; $display("FAIL mac_wbelow got=%h exp=04030201", wbelow); end
    opsel  = op;
    sum_in = {4{base}};
    flush();
    act_in    = 8'd5;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ev = 4'b0001 << (k - 1);
      es = (op ? 32'd0 : base) + 32'(5 * k);
      total++; if (out_valid !== ev) begin bad++; $display("FAIL mac_valid op=%0d k=%0d got=%b exp=%b", op, k, out_valid, ev); end
      total++; if (osum(k-1) !== es) begin bad++; $display("FAIL mac_sum op=%0d pe=%0d got=%0d exp=%0d", op, k-1, osum(k-1), es); end
    end
    tick();
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL mac_valid_end op=%0d got=%b exp=0000", op, out_valid); end
    opsel = 1'b0;
  endtask

  task automatic test_swap_drain();
    int          j;
    logic        ev, er, ed;
    logic [31:0] es;
    sum_in = '0;
    flush();
    for (int k = 0; k <= 8; k++) begin
      act_valid = (k <= 2);
      act_in    = 8'(k + 1);
      w_en      = (k == 0);
      win       = 32'h09090909;
      w_swap    = (k == 2);
      tick();
      er = (k < 2) || (k == 8);
      ed = (k == 8);
      total++; if (act_ready !== er) begin bad++; $display("FAIL drain_ready k=%0d got=%b exp=%b", k, act_ready, er); end
      total++; if (swap_done !== ed) begin bad++; $display("FAIL drain_swap_done k=%0d got=%b exp=%b", k, swap_done, ed); end
      for (int i = 0; i < 4; i++) begin
        j  = k - i - 1;
        ev = (j >= 0) && (j <= 2);
        total++; if (out_valid[i] !== ev) begin bad++; $display("FAIL drain_valid k=%0d pe=%0d got=%b exp=%b", k, i, out_valid[i], ev); end
        if (ev) begin
          es = 32'((j + 1) * (i + 1));
          total++; if (osum(i) !== es) begin bad++; $display("FAIL drain_old_w k=%0d pe=%0d got=%0d exp=%0d", k, i, osum(i), es); end
        end
      end
    end
    act_valid = 1'b0;
    w_en      = 1'b0;
    w_swap    = 1'b0;
    act_in    = 8'd1;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    tick();
    total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL new_w_valid got=%b exp=1", out_valid[0]); end
    total++; if (osum(0) !== 32'd9) begin bad++; $display("FAIL new_w_sum got=%0d exp=9", osum(0)); end
  endtask

  task automatic test_neg();
    load_weights({8'd1, 8'd1, 8'd1, 8'd127});
    sum_in = '0;
    flush();
    act_in    = 8'h80;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    tick();
    total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b exp=1", out_valid[0]); end
    total++; if (osum(0) !== 32'hFFFFC080) begin bad++; $display("FAIL neg_sum got=%h exp=ffffc080", osum(0)); end
  endtask

  task automatic test_overflow();
    s_win  = 16'h0101;
    s_w_en = 1'b1;
    tick();
    s_w_en   = 1'b0;
    s_w_swap = 1'b1;
    tick();
    s_w_swap = 1'b0;
    tick(); tick();
    total++; if (s_swap_done !== 1'b1) begin bad++; $display("FAIL ovf_swap_done got=%b exp=1", s_swap_done); end
    s_sum       = {16'd0, 16'h7FFF};
    s_act_in    = 8'd1;
    s_act_valid = 1'b1;
    tick();
    s_act_valid = 1'b0;
    tick();
    total++; if (s_out_sum[15:0] !== POS_OVF_EXP) begin bad++; $display("FAIL ovf_pos got=%h exp=%h", s_out_sum[15:0], POS_OVF_EXP); end
    s_sum       = {16'd0, 16'h8000};
    s_act_in    = 8'hFF;
    s_act_valid = 1'b1;
    tick();
    s_act_valid = 1'b0;
    tick();
    total++; if (s_out_sum[15:0] !== NEG_OVF_EXP) begin bad++; $display("FAIL ovf_neg got=%h exp=%h", s_out_sum[15:0], NEG_OVF_EXP); end
  endtask

  task automatic test_stall();
    logic [3:0] ev;
    load_weights({8'd4, 8'd3, 8'd2, 8'd1});
    sum_in = '0;
    flush();
    act_in    = 8'd7;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    tick();
    total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL stall_pre_valid got=%b exp=0001", out_valid); end
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL stall_valid s=%0d got=%b exp=0001", s, out_valid); end
      total++; if (osum(0) !== 32'd7 || osum(1) !== 32'd0) begin bad++; $display("FAIL stall_sum s=%0d got=%0d,%0d exp=7,0", s, osum(0), osum(1)); end
      total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL stall_ready s=%0d got=%b exp=0", s, act_ready); end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      ev = 4'b0010 << k;
      total++; if (out_valid !== ev) begin bad++; $display("FAIL stall_resume_valid k=%0d got=%b exp=%b", k, out_valid, ev); end
      total++; if (osum(k+1) !== 32'(7 * (k + 2))) begin bad++; $display("FAIL stall_resume_sum k=%0d got=%0d exp=%0d", k, osum(k+1), 7 * (k + 2)); end
      if (k == 1) begin
        total++; if (act_out_valid !== 1'b1 || act_out !== 8'd7) begin bad++; $display("FAIL stall_act_out got=%b/%0d exp=1/7", act_out_valid, act_out); end
      end
    end
  endtask

  task automatic test_reset_drain();
    logic sd_seen;
    sum_in = '0;
    flush();
    win       = 32'h05050505;
    w_en      = 1'b1;
    act_in    = 8'd2;
    act_valid = 1'b1;
    w_swap    = 1'b1;
    tick();
    w_en = 1'b0; act_valid = 1'b0; w_swap = 1'b0;
    total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL rd_in_drain got=%b exp=0", act_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL rd_ready got=%b exp=1", act_ready); end
    total++; if (out_sum !== '0 || out_valid !== 4'b0) begin bad++; $display("FAIL rd_out got=%h/%b exp=0/0000", out_sum, out_valid); end
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL rd_swap_done got=%b exp=0", swap_done); end
    total++; if (wbelow !== 32'h0) begin bad++; $display("FAIL rd_wbelow got=%h exp=0", wbelow); end
    act_in    = 8'd3;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    sd_seen   = swap_done;
    tick();
    total++; if (out_valid !== 4'b0001 || osum(0) !== 32'd0) begin bad++; $display("FAIL rd_active_zero got=%b/%0d exp=0001/0", out_valid, osum(0)); end
    for (int n = 0; n < 5; n++) begin
      tick();
      sd_seen = sd_seen | swap_done;
    end
    total++; if (sd_seen !== 1'b0) begin bad++; $display("FAIL rd_no_swap_done got=%b exp=0", sd_seen); end
  endtask

  task automatic test_wen_in_swap();
    flush();
    win  = {8'd4, 8'd3, 8'd2, 8'd1};
    w_en = 1'b1;
    tick();
    w_en   = 1'b0;
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    tick();
    total++; if (swap_done !== 1'b0 || act_ready !== 1'b0) begin bad++; $display("FAIL ws_in_swap got=%b/%b exp=0/0", swap_done, act_ready); end
    win  = 32'h08080808;
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
    total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL ws_swap_done got=%b exp=1", swap_done); end
    total++; if (wbelow !== 32'h08080808) begin bad++; $display("FAIL ws_wbelow got=%h exp=08080808", wbelow); end
    act_in    = 8'd2;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
    act_in    = '0;
    tick();
    total++; if (out_valid[0] !== 1'b1 || osum(0) !== 32'd2) begin bad++; $display("FAIL ws_old_shadow0 got=%b/%0d exp=1/2", out_valid[0], osum(0)); end
    tick();
    total++; if (out_valid[1] !== 1'b1 || osum(1) !== 32'd4) begin bad++; $display("FAIL ws_old_shadow1 got=%b/%0d exp=1/4", out_valid[1], osum(1)); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; w_en = 1'b0; w_swap = 1'b0; opsel = 1'b0;
    act_valid = 1'b0; act_in = '0; win = '0; sum_in = '0;
    s_w_en = 1'b0; s_w_swap = 1'b0; s_act_valid = 1'b0; s_act_in = '0; s_win = '0; s_sum = '0;
    test_reset();
    test_mac(1'b0, 32'd10);
    test_mac(1'b1, 32'd1000);
    test_swap_drain();
    test_neg();
    test_overflow();
    test_stall();
    test_reset_drain();
    test_wen_in_swap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
